multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 111 +++++++++++
 tb/tb_multiplier.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// Sequential 32x32 unsigned multiplier using a shift-add loop.
// A start is accepted only in IDLE when Signal carries the MULTU code.
// One add/shift step runs per cycle in RUN. The finished product is published
// on dataOut at the final step, together with a single-cycle done pulse.
module multiplier #(
  parameter logic [5:0]  MULTU = 6'b011001,
  parameter int unsigned STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [63:0] dataOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value seen on the edge that performs the last iteration.
  // STEPS must equal the 32-bit operand width.
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  state_t      state_q,    state_d;
  logic [31:0] mcand_q,    mcand_d;
  logic [63:0] p_q,        p_d;
  logic [5:0]  cnt_q,      cnt_d;
  logic [63:0] data_out_q, data_out_d;
  logic        done_q,     done_d;

  logic [32:0] add_src;
  logic [32:0] sum;
  logic [63:0] step_p;

  // One shift-add iteration. The sum is 33 bits wide so that its carry
  // becomes the new MSB of P when the product is shifted right.
  always_comb begin
    add_src = '0;
    if (p_q[0]) begin
      add_src = {1'b0, mcand_q};
    end
    sum    = {1'b0, p_q[63:32]} + add_src;
    step_p = {sum, p_q[31:1]};
  end

  // Next-state logic and register updates for IDLE, RUN and DONE.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    done_d     = done_q;
    case (state_q)
      IDLE: begin
        if (Signal == MULTU) begin
          mcand_d = dataA;
          p_d     = {32'b0, dataB};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = step_p;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          data_out_d = step_p;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign dataOut = data_out_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier. The stimulus pushes expected products into
// a queue. The monitor compares dataOut against that queue on every done pulse
// and checks that dataOut holds its value between pulses.
module tb_multiplier;

  localparam logic [5:0] MULTU = 6'b011001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;

  multiplier #(.MULTU(MULTU), .STEPS(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .dataOut(dataOut),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_out = '0;
  logic [63:0] mon_e;
  bit          mon_en = 1'b0;
  int          done_seen = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  // A reset edge aborts everything in flight and clears the published product.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      last_out = '0;
    end
  end

  // Monitor: every done pulse pops one expected product; otherwise dataOut must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("product", dataOut, mon_e);
          last_out = mon_e;
        end
      end else begin
        chk("hold_dataOut", dataOut, last_out);
      end
    end
  end

  // Called at a negedge. Returns at a negedge where the DUT is in IDLE.
  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy && !done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 0) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Start one product and perturb the inputs while it runs.
  // Also checks busy width and done latency.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [63:0] expv);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    wait_idle();
    dataA  = a;
    dataB  = b;
    Signal = MULTU;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 100; i++) begin
      Signal = ($urandom_range(0, 1) == 1) ? MULTU : 6'($urandom);
      dataA  = $urandom;
      dataB  = $urandom;
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
      if (busy) nb++;
    end
    Signal = 6'd0;
    chk("done_latency", 64'(n), 64'd33);
    chk("busy_cycles", 64'(nb), 64'd32);
  endtask

  logic [31:0] da[4];
  logic [31:0] db[4];
  logic [63:0] dp[4];

  initial begin : stim
    logic [31:0] a;
    logic [31:0] b;
    int          d0;

    da[0] = 32'd7;          db[0] = 32'd6;          dp[0] = 64'h000000000000002A;
    da[1] = 32'hFFFFFFFF;   db[1] = 32'hFFFFFFFF;   dp[1] = 64'hFFFFFFFE00000001;
    da[2] = 32'h80000000;   db[2] = 32'd2;          dp[2] = 64'h0000000100000000;
    da[3] = 32'd0;          db[3] = 32'h12345678;   dp[3] = 64'h0;

    reset  = 1'b1;
    Signal = 6'd0;
    dataA  = '0;
    dataB  = '0;
    repeat (2) @(negedge clk);
    chk("reset_dataOut", dataOut, 64'h0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed operand pairs, with constant expected products.
    for (int i = 0; i < 4; i++) run_one(da[i], db[i], dp[i]);
    // Keep a nonzero product on dataOut before the opcode checks.
    run_one(32'd7, 32'd6, 64'h2A);

    // Non-MULTU opcodes in IDLE must not start an operation.
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      Signal = (k == 0) ? 6'b011011 : ((k == 1) ? 6'b100000 : 6'b000000);
      for (int j = 0; j < 3; j++) begin
        dataA = $urandom;
        dataB = $urandom;
        @(negedge clk);
        chk("nostart_busy", 64'(busy), 64'd0);
        chk("nostart_done", 64'(done), 64'd0);
      end
    end
    Signal = 6'd0;

    // Random operands, with zero and all-ones values mixed in.
    for (int i = 0; i < 16; i++) begin
      a = (i % 5 == 0) ? 32'd0 : ((i % 7 == 0) ? 32'hFFFFFFFF : $urandom);
      b = (i % 6 == 0) ? 32'hFFFFFFFF : $urandom;
      run_one(a, b, 64'(a) * 64'(b));
    end

    // MULTU held high with fresh operands each cycle.
    // Starts are accepted only every 34 edges.
    wait_idle();
    d0 = done_seen;
    for (int i = 0; i < 102; i++) begin
      a = $urandom;
      b = $urandom;
      dataA  = a;
      dataB  = b;
      Signal = MULTU;
      if (i % 34 == 0) exp_q.push_back(64'(a) * 64'(b));
      @(negedge clk);
    end
    Signal = 6'd0;
    chk("continuous_starts", 64'(done_seen - d0), 64'd3);

    // Reset at cycle 10 of RUN aborts the operation.
    wait_idle();
    chk("pre_abort_dataOut_nonzero", 64'(dataOut != 64'h0), 64'd1);
    dataA  = $urandom;
    dataB  = $urandom;
    Signal = MULTU;
    @(negedge clk);
    Signal = 6'd0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_dataOut", dataOut, 64'h0);
    chk("abort_done", 64'(done), 64'd0);
    d0 = done_seen;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);
    run_one(32'h0001_0000, 32'h0001_0000, 64'h0000000100000000);

    // Reset takes priority over a start on the same edge.
    wait_idle();
    reset  = 1'b1;
    Signal = MULTU;
    dataA  = $urandom;
    dataB  = $urandom;
    @(negedge clk);
    reset  = 1'b0;
    Signal = 6'd0;
    chk("reset_priority_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("reset_priority_busy2", 64'(busy), 64'd0);
    run_one(32'd123456, 32'd654321, 64'd123456 * 64'd654321);

    wait_idle();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
